// File: rtl/m_div_ctrl.sv
// m_div_ctrl: signed/unsigned DIV/REM sequencing around an external unsigned divider
module m_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            div_start_o,
  output logic [XLEN-1:0] div_opr1_o,
  output logic [XLEN-1:0] div_opr2_o,
  input  logic            div_done_i,
  input  logic [XLEN-1:0] div_quo_i,
  input  logic [XLEN-1:0] div_rem_i
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic [1:0]      r_state;
  logic            r_rem, r_s1, r_s2;
  logic [XLEN-1:0] r_opr1, r_opr2, r_result;
  logic            w_s1, w_s2, w_zero, w_ovf;
  logic [XLEN-1:0] w_special, w_quo, w_rem;
  assign w_s1      = ~op_i[0] & rs1_i[XLEN-1];
  assign w_s2      = ~op_i[0] & rs2_i[XLEN-1];
  assign w_zero    = rs2_i == '0;
  assign w_ovf     = ~op_i[0] && rs1_i == MIN_NEG && rs2_i == '1;
  // Divide-by-zero and signed overflow bypass the divider entirely
  assign w_special = w_zero ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
  assign w_quo     = (r_s1 ^ r_s2) ? -div_quo_i : div_quo_i;
  assign w_rem     = r_s1 ? -div_rem_i : div_rem_i;
  assign req_ready_o = r_state == IDLE;
  assign rsp_valid_o = r_state == RESP;
  assign div_start_o = r_state == START;
  assign result_o    = r_result;
  assign div_opr1_o  = r_opr1;
  assign div_opr2_o  = r_opr2;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rem    <= 1'b0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_opr1   <= '0;
      r_opr2   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid_i) begin
          r_rem  <= op_i[1];
          r_s1   <= w_s1;
          r_s2   <= w_s2;
          r_opr1 <= w_s1 ? -rs1_i : rs1_i;
          r_opr2 <= w_s2 ? -rs2_i : rs2_i;
          if (w_zero || w_ovf) begin
            r_result <= w_special;
            r_state  <= RESP;
          end else begin
            r_state <= START;
          end
        end
        START: r_state <= WAIT;
        WAIT: if (div_done_i) begin
          r_result <= r_rem ? w_rem : w_quo;
          r_state  <= RESP;
        end
        default: if (rsp_ready_i) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/m_div_ctrl.md
M_DIV_CTRL -- requirements
Module: m_div_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit, clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, synchronous, active-low.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit, upstream request valid.
REQ-005 The block SHALL have port req_ready_o, output, 1 bit, block can accept a request.
REQ-006 The block SHALL have port op_i, input, 2 bits, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 The block SHALL have port rs1_i, input, XLEN bits, dividend.
REQ-008 The block SHALL have port rs2_i, input, XLEN bits, divisor.
REQ-009 The block SHALL have port rsp_valid_o, output, 1 bit, result valid.
REQ-010 The block SHALL have port rsp_ready_i, input, 1 bit, downstream accepts result.
REQ-011 The block SHALL have port result_o, output, XLEN bits, final signed or unsigned result.
REQ-012 The block SHALL have port div_start_o, output, 1 bit, one-cycle start pulse to the unsigned divider.
REQ-013 The block SHALL have ports div_opr1_o and div_opr2_o, output, XLEN bits each, unsigned dividend and divisor magnitudes to the divider.
REQ-014 The block SHALL have port div_done_i, input, 1 bit, divider completion pulse.
REQ-015 The block SHALL have ports div_quo_i and div_rem_i, input, XLEN bits each, unsigned quotient and remainder from the divider.

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT and RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid_i=1 and req_ready_o=1.
REQ-018 On accept, the block SHALL latch op, the sign of rs1 (s1) and the sign of rs2 (s2), with s1 and s2 forced to 0 for DIVU/REMU.
REQ-019 On accept, the block SHALL latch magnitudes |rs1| and |rs2|; two's-complement negation applies when the latched sign is 1, and -2^(XLEN-1) maps to 2^(XLEN-1) unsigned.
REQ-020 If rs2_i=0 at accept, the block SHALL go directly to RESP with result = all ones for DIV/DIVU and rs1_i for REM/REMU, and SHALL NOT pulse div_start_o.
REQ-021 If op=DIV or REM, rs1_i=0x8000_0000 (MSB only) and rs2_i=all ones at accept, the block SHALL go directly to RESP with result = rs1_i for DIV and 0 for REM, and SHALL NOT pulse div_start_o.
REQ-022 For any other accepted request, the FSM SHALL go IDLE->START.
REQ-023 In START, div_start_o SHALL be 1 for exactly one cycle with the latched magnitudes on div_opr1_o/div_opr2_o; the next state SHALL be WAIT.
REQ-024 div_opr1_o and div_opr2_o SHALL hold their values from START until WAIT exits.
REQ-025 In WAIT, when div_done_i=1, the block SHALL register the result and go to RESP on the next edge.
REQ-026 The WAIT result SHALL be: quotient = div_quo_i negated if s1 XOR s2, else div_quo_i; remainder = div_rem_i negated if s1, else div_rem_i; select quotient for DIV/DIVU and remainder for REM/REMU.
REQ-027 div_done_i SHALL be ignored in any state other than WAIT.
REQ-028 In RESP, rsp_valid_o SHALL be 1 and result_o SHALL be stable until rsp_ready_i=1; the FSM SHALL then go to IDLE on that edge.
REQ-029 A new request SHALL NOT be accepted in the same cycle as the response handshake; the earliest accept is the following cycle.
REQ-030 Latency SHALL be: special cases, rsp_valid_o one cycle after accept; normal cases, rsp_valid_o one cycle after div_done_i.
REQ-031 No internal timeout SHALL exist; WAIT persists until div_done_i.

Reset
REQ-032 While rst=0 at a clock edge, the FSM SHALL enter IDLE, and rsp_valid_o, div_start_o, result_o, div_opr1_o and div_opr2_o SHALL be 0.
REQ-033 Reset in any state, including mid-WAIT or in RESP with a pending result, SHALL discard the operation with no response emitted.
REQ-034 After release of reset, req_ready_o SHALL be 1 on the first cycle.

Verification
REQ-035 The bench SHALL cover: DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; div_opr1_o=7 and div_opr2_o=2.
REQ-036 The bench SHALL cover: DIVU rs1=0xFFFFFFFF, rs2=2 -> result 0x7FFFFFFF; REMU with the same operands -> 1.
REQ-037 The bench SHALL cover: DIV rs1=5, rs2=0 -> 0xFFFFFFFF, and REM rs1=5, rs2=0 -> 5; rsp_valid_o one cycle after accept and div_start_o never asserted.
REQ-038 The bench SHALL cover: DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000, and REM -> 0; no div_start_o.
REQ-039 The bench SHALL cover: rsp_ready_i held at 0 for 5 cycles in RESP -> rsp_valid_o=1, result_o unchanged and req_ready_o=0 throughout; IDLE entered after the handshake.
REQ-040 The bench SHALL cover: rst=0 asserted in WAIT, then div_done_i pulsed after release -> no rsp_valid_o, and the FSM stays in IDLE.
